// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM-state and flag definitions for alu_seq.
// Imported by the alu_seq top and by the alu_seq_mul multiplier.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_NEG  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_XOR  = 3'b101,
      OP_MUL  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: loads on start, then runs WIDTH steps, one per cycle.
// Latency: done is raised WIDTH cycles after the start edge; product holds until the next start.
// Backpressure: none; the caller stops sampling once done is seen.
module alu_seq_mul
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   cnt;
   logic               busy;
   logic [WIDTH:0]     sum;

   // Upper half plus the multiplicand when the multiplier LSB (acc[0]) is set.
   always_comb begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (acc[0]) begin
         sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      end
   end

   assign done    = busy && (cnt == CNT_W'(WIDTH));
   assign product = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         mcand <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         acc   <= {{WIDTH{1'b0}}, b};
         mcand <= a;
         cnt   <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         if (done) begin
            busy <= 1'b0;
         end else begin
            acc <= {sum, acc[WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU (ADD/SUB/NEG/AND/OR/XOR/PASS, MUL under ALU_SEQ_MUL_EN) with valid/ready handshake.
// Latency: 1 cycle accept-to-out_valid, WIDTH+1 for MUL; one operation in flight at a time.
// Backpressure: result and flags hold while out_ready=0; in_ready stays low until the handshake.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state, state_nxt;
   logic [WIDTH-1:0] res_q;
   logic             carry_q, ovf_q;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [WIDTH:0]   sum;
   logic             accept;
   flags_t           flg;

   assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
   logic               is_mul;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign is_mul = (op_e'(op) == OP_MUL);

   alu_seq_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_prod)
   );
`endif

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      sum     = '0;
      case (op_e'(op))
         OP_ADD: begin
            sum     = {1'b0, a} + {1'b0, b};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sum     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_NEG: begin
            alu_res = '0 - a;
            alu_c   = (a == '0);
            alu_v   = (a == MOST_NEG);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_PASS: alu_res = a;
`ifdef ALU_SEQ_MUL_EN
         OP_MUL:  alu_res = '0;
`else
         // Multiplier not built: complete at once with overflow as an error marker.
         OP_MUL:  alu_v   = 1'b1;
`endif
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
`ifdef ALU_SEQ_MUL_EN
               state_nxt = is_mul ? ST_MUL : ST_DONE;
`else
               state_nxt = ST_DONE;
`endif
            end
         end
`ifdef ALU_SEQ_MUL_EN
         ST_MUL: begin
            if (mul_done) state_nxt = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state <= state_nxt;
`ifdef ALU_SEQ_MUL_EN
         if (accept && !is_mul) begin
            res_q   <= alu_res;
            carry_q <= alu_c;
            ovf_q   <= alu_v;
         end else if (state == ST_MUL && mul_done) begin
            res_q   <= mul_prod[WIDTH-1:0];
            carry_q <= |mul_prod[2*WIDTH-1:WIDTH];
            ovf_q   <= 1'b0;
         end
`else
         if (accept) begin
            res_q   <= alu_res;
            carry_q <= alu_c;
            ovf_q   <= alu_v;
         end
`endif
      end
   end

   always_comb begin
      flg.carry    = carry_q;
      flg.overflow = ovf_q;
      flg.zero     = (res_q == '0);
      flg.negative = res_q[WIDTH-1];
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign result    = res_q;
   assign carry     = flg.carry;
   assign overflow  = flg.overflow;
   assign zero      = flg.zero;
   assign negative  = flg.negative;

endmodule
